// File: rtl/pio_pkg.sv
// Shared TLP constants, register map indices and types for the PIO endpoint.
package pio_pkg;

    localparam logic [1:0]  FMT_MRD32      = 2'b00;
    localparam logic [1:0]  FMT_MWR32      = 2'b10;
    localparam logic [4:0]  TYPE_MEM       = 5'b00000;
    localparam logic [31:0] CPLD_DW0       = 32'h4A00_0001;
    localparam logic [31:0] ID_VALUE       = 32'h504E_4D41;
    localparam logic [63:0] XGMII_IDLE_WORD = 64'h0707_0707_0707_0707;
    localparam logic [7:0]  XGMII_START    = 8'hFB;

    localparam int unsigned NUM_RW_REGS = 6;
    localparam int unsigned REG_RXCNT   = 6;
    localparam int unsigned REG_ID      = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR2,
        ST_WAIT_CPL
    } rx_state_e;

    typedef enum logic [1:0] {
        KIND_OTHER,
        KIND_WR,
        KIND_RD
    } tlp_kind_e;

    typedef struct packed {
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [6:0]  addr;
    } req_info_t;

    // Only 3DW memory requests of exactly one dword are serviced.
    function automatic tlp_kind_e decode_tlp(input logic [1:0] fmt,
                                             input logic [4:0] typ,
                                             input logic [9:0] len);
        if (typ != TYPE_MEM || len != 10'd1) return KIND_OTHER;
        if (fmt == FMT_MWR32) return KIND_WR;
        if (fmt == FMT_MRD32) return KIND_RD;
        return KIND_OTHER;
    endfunction

endpackage

// File: rtl/pio_xgmii_port.sv
// XGMII port: counts RX start characters on lane 0; TX idles, or loops RX back
// when PIO_XGMII_LOOPBACK_EN is defined.
module pio_xgmii_port
    import pio_pkg::*;
#(
    parameter logic [63:0] IDLE_WORD = XGMII_IDLE_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] rxd,
    input  logic [7:0]  rxc,
    output logic [63:0] txd,
    output logic [7:0]  txc,
    output logic [31:0] rx_frames
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_frames <= '0;
        end else if (rxd[7:0] == XGMII_START && rxc[0]) begin
            rx_frames <= rx_frames + 32'd1;
        end
    end

`ifdef PIO_XGMII_LOOPBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd <= IDLE_WORD;
            txc <= 8'hFF;
        end else begin
            txd <= rxd;
            txc <= rxc;
        end
    end
`else
    logic unused_rx_c;
    assign unused_rx_c = ^{rxd[63:8], rxc[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd <= IDLE_WORD;
            txc <= 8'hFF;
        end else begin
            txd <= IDLE_WORD;
            txc <= 8'hFF;
        end
    end
`endif

endmodule

// File: rtl/pio_regfile_xgmii.sv
// PCIe PIO endpoint: 1-DW MWr/MRd into a small config register file with CplD
// replies, plus an XGMII port. Optional loopback: PIO_XGMII_LOOPBACK_EN.
module pio_regfile_xgmii
    import pio_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter logic [63:0] XGMII_IDLE = XGMII_IDLE_WORD
) (
    input  logic        user_clk,
    input  logic        user_reset,
    input  logic        user_lnk_up,
    input  logic        s_axis_tx_tready,
    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    output logic        tx_src_dsc,
    input  logic [63:0] m_axis_rx_tdata,
    input  logic [7:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tlast,
    input  logic        m_axis_rx_tvalid,
    output logic        m_axis_rx_tready,
    input  logic [21:0] m_axis_rx_tuser,
    input  logic        cfg_to_turnoff,
    output logic        cfg_turnoff_ok,
    input  logic [15:0] cfg_completer_id,
    output logic [31:0] if_v4addr,
    output logic [47:0] if_macaddr,
    output logic [31:0] dest_v4addr,
    output logic [47:0] dest_macaddr,
    output logic [63:0] xgmii_0_txd,
    output logic [7:0]  xgmii_0_txc,
    input  logic [63:0] xgmii_0_rxd,
    input  logic [7:0]  xgmii_0_rxc
);

    rx_state_e          state_q, state_d;
    tlp_kind_e          kind_q, kind_d;
    req_info_t          req_q, req_d;
    logic [3:0]         be_q, be_d;
    logic [REG_AW-1:0]  rd_idx_q, rd_idx_d;
    logic               tvalid_d, tlast_d, rx_tready_d;
    logic [7:0]         tkeep_d;
    logic [63:0]        tdata_d;

    logic               wr_en_c;
    logic [REG_AW-1:0]  wr_idx_c;
    logic [31:0]        rd_data_c;
    logic               rx_beat_c;
    logic [31:0]        rx_frames;
    logic [31:0]        regs_q [NUM_RW_REGS];

    logic unused_c;
    assign unused_c = ^{m_axis_rx_tkeep, m_axis_rx_tuser, m_axis_rx_tdata};

    assign tx_src_dsc   = 1'b0;
    assign if_v4addr    = regs_q[0];
    assign if_macaddr   = {regs_q[2][15:0], regs_q[1]};
    assign dest_v4addr  = regs_q[3];
    assign dest_macaddr = {regs_q[5][15:0], regs_q[4]};

    assign rx_beat_c = m_axis_rx_tvalid & m_axis_rx_tready;
    assign wr_idx_c  = m_axis_rx_tdata[REG_AW+1:2];

    // Read mux for the completion payload.
    always_comb begin
        rd_data_c = '0;
        for (int r = 0; r < NUM_RW_REGS; r++) begin
            if (rd_idx_q == REG_AW'(r)) rd_data_c = regs_q[r];
        end
        if (rd_idx_q == REG_AW'(REG_RXCNT)) rd_data_c = rx_frames;
        if (rd_idx_q == REG_AW'(REG_ID))    rd_data_c = ID_VALUE;
    end

    // Next-state and output decode for the RX/completion machine.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        req_d    = req_q;
        be_d     = be_q;
        rd_idx_d = rd_idx_q;
        tvalid_d = s_axis_tx_tvalid;
        tlast_d  = s_axis_tx_tlast;
        tkeep_d  = s_axis_tx_tkeep;
        tdata_d  = s_axis_tx_tdata;
        wr_en_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_beat_c) begin
                    kind_d = decode_tlp(m_axis_rx_tdata[30:29], m_axis_rx_tdata[28:24],
                                        m_axis_rx_tdata[9:0]);
                    req_d.req_id = m_axis_rx_tdata[63:48];
                    req_d.tag    = m_axis_rx_tdata[47:40];
                    be_d         = m_axis_rx_tdata[35:32];
                    if (!m_axis_rx_tlast) state_d = ST_HDR2;
                end
            end
            ST_HDR2: begin
                if (rx_beat_c) begin
                    case (kind_q)
                        KIND_WR: begin
                            wr_en_c = 1'b1;
                            kind_d  = KIND_OTHER;
                            state_d = m_axis_rx_tlast ? ST_IDLE : ST_HDR2;
                        end
                        KIND_RD: begin
                            req_d.addr = m_axis_rx_tdata[6:0];
                            rd_idx_d   = m_axis_rx_tdata[REG_AW+1:2];
                            state_d    = ST_WAIT_CPL;
                        end
                        default: begin
                            if (m_axis_rx_tlast) state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_WAIT_CPL: begin
                if (!s_axis_tx_tvalid) begin
                    if (user_lnk_up) begin
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                        tkeep_d  = 8'hFF;
                        tdata_d  = {cfg_completer_id, 16'h0004, CPLD_DW0};
                    end
                end else if (s_axis_tx_tready) begin
                    if (!s_axis_tx_tlast) begin
                        tlast_d = 1'b1;
                        tdata_d = {rd_data_c, req_q.req_id, req_q.tag, 1'b0, req_q.addr};
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tkeep_d  = 8'h00;
                        tdata_d  = '0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rx_tready_d = (state_d != ST_WAIT_CPL);
    end

    always_ff @(posedge user_clk or negedge user_reset) begin
        if (!user_reset) begin
            state_q          <= ST_IDLE;
            kind_q           <= KIND_OTHER;
            req_q            <= '0;
            be_q             <= '0;
            rd_idx_q         <= '0;
            s_axis_tx_tvalid <= 1'b0;
            s_axis_tx_tlast  <= 1'b0;
            s_axis_tx_tkeep  <= 8'h00;
            s_axis_tx_tdata  <= '0;
            m_axis_rx_tready <= 1'b1;
            cfg_turnoff_ok   <= 1'b0;
        end else begin
            state_q          <= state_d;
            kind_q           <= kind_d;
            req_q            <= req_d;
            be_q             <= be_d;
            rd_idx_q         <= rd_idx_d;
            s_axis_tx_tvalid <= tvalid_d;
            s_axis_tx_tlast  <= tlast_d;
            s_axis_tx_tkeep  <= tkeep_d;
            s_axis_tx_tdata  <= tdata_d;
            m_axis_rx_tready <= rx_tready_d;
            cfg_turnoff_ok   <= cfg_to_turnoff & (state_q != ST_WAIT_CPL) & ~s_axis_tx_tvalid;
        end
    end

    // Byte-enabled writes; indices beyond the read/write block are dropped.
    always_ff @(posedge user_clk or negedge user_reset) begin
        if (!user_reset) begin
            for (int r = 0; r < NUM_RW_REGS; r++) regs_q[r] <= '0;
        end else if (wr_en_c) begin
            for (int r = 0; r < NUM_RW_REGS; r++) begin
                if (wr_idx_c == REG_AW'(r)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_q[b]) regs_q[r][8*b +: 8] <= m_axis_rx_tdata[32 + 8*b +: 8];
                    end
                end
            end
        end
    end

    pio_xgmii_port #(
        .IDLE_WORD (XGMII_IDLE)
    ) u_xgmii (
        .clk       (user_clk),
        .rst_n     (user_reset),
        .rxd       (xgmii_0_rxd),
        .rxc       (xgmii_0_rxc),
        .txd       (xgmii_0_txd),
        .txc       (xgmii_0_txc),
        .rx_frames (rx_frames)
    );

endmodule

// File: tb/tb_pio_regfile_xgmii.sv
// Directed self-checking bench for pio_regfile_xgmii.
module tb_pio_regfile_xgmii;

    logic        user_clk = 1'b0;
    logic        user_reset;
    logic        user_lnk_up;
    logic        s_axis_tx_tready;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        tx_src_dsc;
    logic [63:0] m_axis_rx_tdata;
    logic [7:0]  m_axis_rx_tkeep;
    logic        m_axis_rx_tlast;
    logic        m_axis_rx_tvalid;
    logic        m_axis_rx_tready;
    logic [21:0] m_axis_rx_tuser;
    logic        cfg_to_turnoff;
    logic        cfg_turnoff_ok;
    logic [15:0] cfg_completer_id;
    logic [31:0] if_v4addr;
    logic [47:0] if_macaddr;
    logic [31:0] dest_v4addr;
    logic [47:0] dest_macaddr;
    logic [63:0] xgmii_0_txd;
    logic [7:0]  xgmii_0_txc;
    logic [63:0] xgmii_0_rxd;
    logic [7:0]  xgmii_0_rxc;

    int passed = 0;
    int total  = 0;

    localparam logic [63:0] IDLE = 64'h0707_0707_0707_0707;

    always #5 user_clk = ~user_clk;

    pio_regfile_xgmii dut (
        .user_clk         (user_clk),
        .user_reset       (user_reset),
        .user_lnk_up      (user_lnk_up),
        .s_axis_tx_tready (s_axis_tx_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .tx_src_dsc       (tx_src_dsc),
        .m_axis_rx_tdata  (m_axis_rx_tdata),
        .m_axis_rx_tkeep  (m_axis_rx_tkeep),
        .m_axis_rx_tlast  (m_axis_rx_tlast),
        .m_axis_rx_tvalid (m_axis_rx_tvalid),
        .m_axis_rx_tready (m_axis_rx_tready),
        .m_axis_rx_tuser  (m_axis_rx_tuser),
        .cfg_to_turnoff   (cfg_to_turnoff),
        .cfg_turnoff_ok   (cfg_turnoff_ok),
        .cfg_completer_id (cfg_completer_id),
        .if_v4addr        (if_v4addr),
        .if_macaddr       (if_macaddr),
        .dest_v4addr      (dest_v4addr),
        .dest_macaddr     (dest_macaddr),
        .xgmii_0_txd      (xgmii_0_txd),
        .xgmii_0_txc      (xgmii_0_txc),
        .xgmii_0_rxd      (xgmii_0_rxd),
        .xgmii_0_rxc      (xgmii_0_rxc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    // Presents one RX beat and returns just after the edge that accepts it.
    task automatic rx_send(input logic [63:0] data, input logic last);
        int n = 0;
        m_axis_rx_tdata  = data;
        m_axis_rx_tlast  = last;
        m_axis_rx_tvalid = 1'b1;
        while (!m_axis_rx_tready && n < 50) begin
            tick();
            n++;
        end
        chk("rx_tready_wait", 64'(n < 50), 64'd1);
        tick();
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast  = 1'b0;
    endtask

    task automatic mwr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        rx_send({16'h0100, 8'h00, 4'h0, be, 32'h4000_0001}, 1'b0);
        rx_send({data, addr}, 1'b1);
    endtask

    task automatic do_mrd(input logic [31:0] addr, input logic [7:0] tag,
                          input logic [31:0] exp_data, input int stall, input int link_hold);
        int n = 0;
        if (link_hold > 0) user_lnk_up = 1'b0;
        rx_send({16'h0100, tag, 8'h0F, 32'h0000_0001}, 1'b0);
        rx_send({32'h0, addr}, 1'b1);
        chk("rx_tready_low_after_mrd", 64'(m_axis_rx_tready), 64'd0);
        if (link_hold > 0) begin
            repeat (link_hold) tick();
            chk("cpl_held_link_down", 64'(s_axis_tx_tvalid), 64'd0);
            user_lnk_up = 1'b1;
        end
        if (stall > 0) s_axis_tx_tready = 1'b0;
        while (!s_axis_tx_tvalid && n < 20) begin
            tick();
            n++;
        end
        chk("cpl_tvalid_wait", 64'(s_axis_tx_tvalid), 64'd1);
        chk("cpl_beat0", s_axis_tx_tdata, {32'h0210_0004, 32'h4A00_0001});
        chk("cpl_beat0_ctl", {54'h0, s_axis_tx_tkeep, 1'b0, s_axis_tx_tlast}, {54'h0, 8'hFF, 2'b00});
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_beat0_held", s_axis_tx_tdata, {32'h0210_0004, 32'h4A00_0001});
            chk("stall_flags", {61'h0, s_axis_tx_tvalid, m_axis_rx_tready, cfg_turnoff_ok},
                {61'h0, 3'b100});
        end
        s_axis_tx_tready = 1'b1;
        tick();
        chk("cpl_beat1", s_axis_tx_tdata, {exp_data, 16'h0100, tag, 1'b0, addr[6:0]});
        chk("cpl_beat1_ctl", {54'h0, s_axis_tx_tkeep, s_axis_tx_tvalid, s_axis_tx_tlast},
            {54'h0, 8'hFF, 2'b11});
        tick();
        chk("cpl_done", {62'h0, s_axis_tx_tvalid, m_axis_rx_tready}, {62'h0, 2'b01});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        user_reset       = 1'b1;
        user_lnk_up      = 1'b1;
        s_axis_tx_tready = 1'b1;
        m_axis_rx_tdata  = '0;
        m_axis_rx_tkeep  = 8'hFF;
        m_axis_rx_tlast  = 1'b0;
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tuser  = '0;
        cfg_to_turnoff   = 1'b0;
        cfg_completer_id = 16'h0210;
        xgmii_0_rxd      = IDLE;
        xgmii_0_rxc      = 8'hFF;
        #3 user_reset = 1'b0;
        repeat (3) tick();

        chk("rst_rx_tready", 64'(m_axis_rx_tready), 64'd1);
        chk("rst_tx", {s_axis_tx_tdata[62:0], s_axis_tx_tvalid}, 64'd0);
        chk("rst_tx_ctl", {54'h0, s_axis_tx_tkeep, s_axis_tx_tlast, tx_src_dsc}, 64'd0);
        chk("rst_if_v4", 64'(if_v4addr), 64'd0);
        chk("rst_if_mac", 64'(if_macaddr), 64'd0);
        chk("rst_dest", {dest_v4addr, 32'h0} | 64'(dest_macaddr), 64'd0);
        chk("rst_txd", xgmii_0_txd, IDLE);
        chk("rst_txc", 64'(xgmii_0_txc), 64'hFF);
        chk("rst_turnoff", 64'(cfg_turnoff_ok), 64'd0);

        user_reset = 1'b1;
        tick();
        chk("post_rst_txd", {xgmii_0_txd[55:0], xgmii_0_txc}, {IDLE[55:0], 8'hFF});

        mwr(32'h00, 32'h0A00_0001, 4'hF);
        mwr(32'h04, 32'h3322_1100, 4'hF);
        mwr(32'h08, 32'h0000_5544, 4'hF);
        tick();
        chk("if_v4addr", 64'(if_v4addr), 64'h0A00_0001);
        chk("if_macaddr", 64'(if_macaddr), 64'h5544_3322_1100);

        mwr(32'h0C, 32'hC0A8_0001, 4'hF);
        mwr(32'h10, 32'hDDCC_BBAA, 4'hF);
        mwr(32'h14, 32'h1234_0066, 4'hF);
        tick();
        chk("dest_v4addr", 64'(dest_v4addr), 64'hC0A8_0001);
        chk("dest_macaddr", 64'(dest_macaddr), 64'h0066_DDCC_BBAA);

        cfg_to_turnoff = 1'b1;
        tick();
        chk("turnoff_idle", 64'(cfg_turnoff_ok), 64'd1);
        cfg_to_turnoff = 1'b0;
        tick();
        chk("turnoff_drop", 64'(cfg_turnoff_ok), 64'd0);

        do_mrd(32'h0C, 8'h05, 32'hC0A8_0001, 0, 0);

        cfg_to_turnoff = 1'b1;
        do_mrd(32'h14, 8'h21, 32'h1234_0066, 3, 0);
        tick();
        chk("turnoff_after_cpl", 64'(cfg_turnoff_ok), 64'd1);
        cfg_to_turnoff = 1'b0;

        do_mrd(32'h1C, 8'h33, 32'h504E_4D41, 0, 4);
        do_mrd(32'h20, 8'h34, 32'h0000_0000, 0, 0);

        for (int i = 0; i < 3; i++) begin
            xgmii_0_rxd = 64'h0707_0707_0707_07FB;
            xgmii_0_rxc = 8'h01;
            tick();
            xgmii_0_rxd = IDLE;
            xgmii_0_rxc = 8'hFF;
            tick();
        end
        xgmii_0_rxd = 64'h0707_0707_0707_07FB;
        xgmii_0_rxc = 8'h00;
        tick();
        xgmii_0_rxd = IDLE;
        xgmii_0_rxc = 8'hFF;
        tick();
        mwr(32'h18, 32'hFFFF_FFFF, 4'hF);
        do_mrd(32'h18, 8'h40, 32'h0000_0003, 0, 0);

        mwr(32'h00, 32'hAABB_CCDD, 4'h3);
        tick();
        chk("be_partial", 64'(if_v4addr), 64'h0A00_CCDD);

        rx_send({16'h0100, 8'h00, 8'h0F, 32'h4000_0002}, 1'b0);
        rx_send({32'h1111_1111, 32'h0000_0000}, 1'b0);
        rx_send({32'h0, 32'h2222_2222}, 1'b1);
        tick();
        chk("len2_ignored", 64'(if_v4addr), 64'h0A00_CCDD);
        do_mrd(32'h00, 8'h41, 32'h0A00_CCDD, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pio_regfile_xgmii.md
Name: pio_regfile_xgmii

Overview:
- PCIe programmed-I/O endpoint on the 64-bit Xilinx-style AXI4-Stream TLP interface.
- Decodes 1-DW memory reads and writes into a small register file and returns completions with data (CplD) for reads.
- Exports the registers as network configuration: interface/destination IPv4 and MAC addresses.
- Provides an XGMII port pair: RX frame counting, TX held idle.

Parameters:
- REG_AW, 5, dword-address bits decoded from the TLP address (addr[REG_AW+1:2]).
- XGMII_IDLE, 64'h0707070707070707, TX idle word.

Ports:
- user_clk  in  1  single clock; all logic, including XGMII, is on this clock.
- user_reset  in  1  asynchronous, active-low reset.
- user_lnk_up  in  1  link up; TX is held idle while low.
- s_axis_tx_tready  in  1  TX ready.
- s_axis_tx_tdata  out  64  TX TLP data.
- s_axis_tx_tkeep  out  8  TX byte enables.
- s_axis_tx_tlast  out  1  TX last beat.
- s_axis_tx_tvalid  out  1  TX valid.
- tx_src_dsc  out  1  TX discontinue; constant 0.
- m_axis_rx_tdata  in  64  RX TLP data.
- m_axis_rx_tkeep  in  8  RX byte enables.
- m_axis_rx_tlast  in  1  RX last beat.
- m_axis_rx_tvalid  in  1  RX valid.
- m_axis_rx_tready  out  1  RX ready.
- m_axis_rx_tuser  in  22  RX sideband; ignored.
- cfg_to_turnoff  in  1  turn-off request.
- cfg_turnoff_ok  out  1  turn-off acknowledge.
- cfg_completer_id  in  16  {bus, dev, func}.
- if_v4addr  out  32  register 0x00.
- if_macaddr  out  48  {reg 0x08[15:0], reg 0x04}.
- dest_v4addr  out  32  register 0x0C.
- dest_macaddr  out  48  {reg 0x14[15:0], reg 0x10}.
- xgmii_0_txd  out  64  XGMII TX data.
- xgmii_0_txc  out  8  XGMII TX control.
- xgmii_0_rxd  in  64  XGMII RX data.
- xgmii_0_rxc  in  8  XGMII RX control.

Behaviour:
Reset values (all outputs):
- Registers: 0.
- tvalid = 0, tlast = 0, tkeep = 0, tdata = 0.
- m_axis_rx_tready = 1.
- xgmii_0_txd = XGMII_IDLE, xgmii_0_txc = 8'hFF.
- RX frame counter = 0.
- cfg_turnoff_ok = 0.

RX state machine (IDLE -> HDR2 -> WAIT_CPL):
- A beat transfers when m_axis_rx_tvalid & m_axis_rx_tready.
- Beat 0 layout: DW0 = tdata[31:0] (fmt[30:29], type[28:24], length[9:0]); DW1 = tdata[63:32] (requester ID[31:16], tag[15:8], BE[7:0]).
- Beat 1 layout: address = tdata[31:0]; write data = tdata[63:32], used as-is with no byte swap.
- MWr32 accepted when fmt = 2'b10, type = 0, length = 1; on beat 1 the register at addr[6:2] is written. Only first-DW BE bits that are set update their bytes.
- MRd32 accepted when fmt = 2'b00, type = 0, length = 1; on beat 1 the machine latches requester ID, tag and addr[6:0], then goes to WAIT_CPL.
- m_axis_rx_tready = 0 in WAIT_CPL.
- All other TLPs (4DW, length ≠ 1, other types) are consumed until tlast and produce no side effect.

Register map (dword index):
- 0..5 read/write: if_v4addr, if_mac_lo, if_mac_hi, dest_v4addr, dest_mac_lo, dest_mac_hi. Hi registers keep all 32 bits; outputs use [15:0].
- 6: RX frame counter, read-only; writes ignored.
- 7: constant 32'h504E4D41, read-only.
- Others: read 0, writes ignored.

TX completion (starts 1 cycle after the MRd beat 1):
- Beat 0, tkeep FF: DW0 = 32'h4A000001; DW1 = {cfg_completer_id, 3'b000 status, 1'b0, 12'd4 byte count}.
- Beat 1, tkeep FF, tlast: DW2 = {req_id, tag, 1'b0, addr[6:0]}; DW3 = register data.
- Each beat is held until s_axis_tx_tready. After the final beat, return to IDLE.
- If user_lnk_up is low, the completion is held and not sent.

Turn-off:
- cfg_turnoff_ok = registered (cfg_to_turnoff & state ≠ WAIT_CPL & !tvalid).

XGMII:
- TX permanently outputs idle.
- RX counter increments, wrapping, when xgmii_0_rxd[7:0] = 8'hFB and xgmii_0_rxc[0] = 1.

Optional Feature:
- Macro: PIO_XGMII_LOOPBACK_EN.
- Defined: xgmii_0_txd/txc = rxd/rxc registered one cycle.
- Undefined: TX permanently idle.

Decomposition:
- Package pio_pkg holds TLP fmt/type constants, CplD DW0 constant, register index localparams, and XGMII_IDLE.
- One sub-module, pio_xgmii_port: RX frame counter plus TX idle/loopback.

Test Plan:
- Reset, then observe outputs → tready = 1, tvalid = 0, all address outputs 0, txc = FF, txd = 0707070707070707.
- MWr addr 0x00, data 0A000001, BE 0F; then MWr 0x04 = 33221100 and MWr 0x08 = 5544 → if_v4addr = 0A000001, if_macaddr = 554433221100.
- MRd tag 0x05 addr 0x0C, after MWr 0x0C = C0A80001, requester 0x0100; completer ID 0x0210 → beat 0 = 02100004_4A000001; beat 1 = C0A80001_0100050C with tlast; tready low until done.
- During completion, drive s_axis_tx_tready low for 3 cycles → beat held stable; rx tready stays 0.
- Drive 3 XGMII RX frames (lane0 FB, rxc 01), then MRd 0x18 → completion data 3; MWr with BE 0x3 to reg 0 → only bytes 0–1 change.
- cfg_to_turnoff = 1 while idle → cfg_turnoff_ok = 1 next cycle; during WAIT_CPL → stays 0 until the completion finishes.
